gc_flush_sequencer: RTL and testbench
=====================================

GC_FLUSH_SEQUENCER -- requirements
Module: gc_flush_sequencer

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of flush-request channels; index 0 is highest priority.
REQ-002 SHALL have parameter SETTLE_MASK, default 4'b1000: channels that need a settle period before draining (interrupt-type).
REQ-003 SHALL have parameter DRAIN_MASK, default 4'b1111: channels that wait for post-issue idle before flushing.
REQ-004 SHALL have parameter TLB_MASK, default 4'b0010: channels followed by a TLB clear.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 2: settle length in cycles, range 1..15.
REQ-006 SHALL have parameters INIT_CLEAR_DEPTH, default 64, and TLB_CLEAR_DEPTH, default 64: both powers of two.
REQ-007 SHALL have parameter COUNT_W, default 7: width of post_issue_count.
REQ-008 clk  in  1  sole clock; all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 req  in  NUM_REQ  level flush requests; each held until granted or withdrawn.
REQ-011 oldest_exception  in  1  exception on the oldest in-flight instruction.
REQ-012 post_issue_count  in  COUNT_W  issued-but-unretired instruction count.
REQ-013 sq_empty  in  1; stores_drained  in  1  store-queue status.
REQ-014 grant  out  NUM_REQ  one-hot, combinational, 1-cycle pulse.
REQ-015 exception_taken  out  1  combinational, 1-cycle pulse.
REQ-016 fetch_hold, issue_hold, writeback_supress, retire_hold, init_clear, tlb_flush, sq_flush, pc_override  out  1 each  registered global controls.
REQ-017 busy  out  1  combinational; high when state is not IDLE.

Function
REQ-018 States SHALL be RST, INIT_CLEAR, IDLE, SETTLE, DRAIN, FLUSH, DISCARD, TLB_CLEAR.
REQ-019 RST SHALL go to INIT_CLEAR; INIT_CLEAR SHALL last exactly INIT_CLEAR_DEPTH cycles, then go to IDLE.
REQ-020 IDLE with oldest_exception SHALL go to FLUSH and pulse exception_taken; this takes precedence over any req.
REQ-021 IDLE with any req SHALL latch the lowest asserted index into sel; next state is SETTLE if SETTLE_MASK[sel], else DRAIN if DRAIN_MASK[sel], else FLUSH.
REQ-022 SETTLE SHALL count SETTLE_CYCLES cycles; on expiry with req[sel] still high it goes to DRAIN/FLUSH per DRAIN_MASK[sel].
REQ-023 SETTLE: if req[sel] drops before expiry, SHALL return to IDLE with no grant.
REQ-024 DRAIN SHALL go to FLUSH when post_issue_count==0 and sq_empty.
REQ-025 oldest_exception in SETTLE or DRAIN SHALL preempt: go to FLUSH, pulse exception_taken, give no grant to sel, and clear the pending TLB flag.
REQ-026 grant[sel] SHALL pulse in the cycle next_state becomes FLUSH from a request path; grant and exception_taken are never high together.
REQ-027 FLUSH SHALL last 1 cycle, then go to DISCARD.
REQ-028 DISCARD SHALL exit when post_issue_count==0 and stores_drained: to TLB_CLEAR if the TLB flag is set, else to IDLE.
REQ-029 TLB_CLEAR SHALL last exactly TLB_CLEAR_DEPTH cycles, then go to IDLE.
REQ-030 Registered outputs SHALL update one cycle after next_state, decoded from next_state:
- fetch_hold: INIT_CLEAR, DRAIN, FLUSH
- issue_hold: every state except IDLE and RST
- writeback_supress: INIT_CLEAR, DISCARD
- retire_hold: FLUSH
- init_clear: INIT_CLEAR
- tlb_flush: INIT_CLEAR, TLB_CLEAR
- pc_override: INIT_CLEAR, FLUSH
REQ-031 sq_flush SHALL pulse 1 cycle after a DISCARD exit transition.
REQ-032 The state counter SHALL be $clog2(max depth)+1 bits wide, clear on entry to any counted state, and never wrap.
REQ-033 Requests arriving outside IDLE SHALL be ignored until IDLE; no request queueing.

Reset
REQ-034 rst SHALL force state to RST, counter and sel to 0, and TLB flag to 0.
REQ-035 rst SHALL force every registered output to 0 the next cycle; grant and exception_taken are 0 while rst is high.
REQ-036 Asserting rst in any state, mid-operation, SHALL abort the sequence and restart from RST.

Structure
REQ-037 The state enum type and flush-control output struct SHALL live in cva5_types.
REQ-038 One sub-module, gc_priority_select (lowest-index one-hot plus encoded index), is natural.

Verification
REQ-039 Reset release -> busy for 1+64 cycles; init_clear and tlb_flush high for 64 cycles; then IDLE with all outputs 0.
REQ-040 req=4'b1000 held, count=0, sq_empty=1 -> SETTLE 2 cycles, DRAIN 1, grant=4'b1000, retire_hold 1 cycle.
REQ-041 req=4'b1010 simultaneously -> grant=4'b0010; DISCARD then TLB_CLEAR 64 cycles; sq_flush pulses once.
REQ-042 req=4'b0001 with count=5 decrementing to 0 over 5 cycles -> fetch_hold stays high until FLUSH; grant only after count hits 0.
REQ-043 oldest_exception in DRAIN cycle 3 -> exception_taken, no grant, no TLB_CLEAR.
REQ-044 req[3] dropped in SETTLE cycle 1 -> return to IDLE with grant never asserted; rst during TLB_CLEAR -> RST next cycle.

Source files
------------

// File: rtl/cva5_types.sv
// Shared types for the global-control flush sequencer: FSM state encoding,
// the bundle of registered pipeline controls, and the state-to-control decode.
package cva5_types;

  typedef enum logic [2:0] {
    RST,
    INIT_CLEAR,
    IDLE,
    SETTLE,
    DRAIN,
    FLUSH,
    DISCARD,
    TLB_CLEAR
  } gc_state_t;

  typedef struct packed {
    logic fetch_hold;
    logic issue_hold;
    logic writeback_supress;
    logic retire_hold;
    logic init_clear;
    logic tlb_flush;
    logic sq_flush;
    logic pc_override;
  } gc_ctrl_t;

  // Pipeline controls implied by being in a given state; sq_flush is not a
  // state property (it marks a DISCARD exit) and is left at zero here.
  function automatic gc_ctrl_t decode_ctrl(input gc_state_t s);
    gc_ctrl_t c;
    c = '0;
    c.fetch_hold        = (s == INIT_CLEAR) || (s == DRAIN) || (s == FLUSH);
    c.issue_hold        = (s != IDLE) && (s != RST);
    c.writeback_supress = (s == INIT_CLEAR) || (s == DISCARD);
    c.retire_hold       = (s == FLUSH);
    c.init_clear        = (s == INIT_CLEAR);
    c.tlb_flush         = (s == INIT_CLEAR) || (s == TLB_CLEAR);
    c.pc_override       = (s == INIT_CLEAR) || (s == FLUSH);
    return c;
  endfunction

endpackage

// File: rtl/gc_priority_select.sv
// Fixed-priority picker: the lowest asserted request index wins. Produces
// both the one-hot winner and its encoded index.
module gc_priority_select #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the last hit (lowest index) overrides the rest.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/gc_flush_sequencer.sv
// Global-control flush sequencer. Arbitrates flush requests and the oldest-
// instruction exception, walks the pipeline through settle/drain/flush/
// discard, and optionally follows with a TLB clear. Also runs the power-on
// state clear after reset.
module gc_flush_sequencer
  import cva5_types::*;
#(
  parameter int                 NUM_REQ          = 4,
  parameter logic [NUM_REQ-1:0] SETTLE_MASK      = 4'b1000,
  parameter logic [NUM_REQ-1:0] DRAIN_MASK       = 4'b1111,
  parameter logic [NUM_REQ-1:0] TLB_MASK         = 4'b0010,
  parameter int                 SETTLE_CYCLES    = 2,
  parameter int                 INIT_CLEAR_DEPTH = 64,
  parameter int                 TLB_CLEAR_DEPTH  = 64,
  parameter int                 COUNT_W          = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               oldest_exception,
  input  logic [COUNT_W-1:0] post_issue_count,
  input  logic               sq_empty,
  input  logic               stores_drained,
  output logic [NUM_REQ-1:0] grant,
  output logic               exception_taken,
  output logic               fetch_hold,
  output logic               issue_hold,
  output logic               writeback_supress,
  output logic               retire_hold,
  output logic               init_clear,
  output logic               tlb_flush,
  output logic               sq_flush,
  output logic               pc_override,
  output logic               busy
);

  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH_A     = (INIT_CLEAR_DEPTH > TLB_CLEAR_DEPTH) ? INIT_CLEAR_DEPTH : TLB_CLEAR_DEPTH;
  localparam int MAX_DEPTH   = (DEPTH_A > SETTLE_CYCLES) ? DEPTH_A : SETTLE_CYCLES;
  localparam int CNT_W       = $clog2(MAX_DEPTH) + 1;

  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CLEAR_DEPTH - 1);
  localparam logic [CNT_W-1:0] TLB_LAST    = CNT_W'(TLB_CLEAR_DEPTH - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  gc_state_t          state;
  gc_state_t          next_state;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   sel;
  logic               tlb_pending;
  gc_ctrl_t           ctrl;
  gc_ctrl_t           ctrl_next;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] sel_onehot;
  logic               req_sel;
  logic               drained;
  logic               discard_done;
  logic               preempt;

  gc_priority_select #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_priority_select (
    .req    (req),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign sel_onehot   = NUM_REQ'(1) << sel;
  assign req_sel      = req[sel];
  assign drained      = (post_issue_count == '0) && sq_empty;
  assign discard_done = (post_issue_count == '0) && stores_drained;
  assign preempt      = oldest_exception;
  assign busy         = (state != IDLE);

  // Next-state selection plus the single-cycle grant / exception pulses, which
  // must fire in the same cycle the machine commits to FLUSH.
  always_comb begin
    next_state      = state;
    grant           = '0;
    exception_taken = 1'b0;
    unique case (state)
      RST: next_state = INIT_CLEAR;
      INIT_CLEAR: begin
        if (count == INIT_LAST) next_state = IDLE;
      end
      IDLE: begin
        if (preempt) begin
          next_state      = FLUSH;
          exception_taken = 1'b1;
        end else if (pick_any) begin
          if (SETTLE_MASK[pick_idx])     next_state = SETTLE;
          else if (DRAIN_MASK[pick_idx]) next_state = DRAIN;
          else begin
            next_state = FLUSH;
            grant      = pick_onehot;
          end
        end
      end
      SETTLE: begin
        if (preempt) begin
          next_state      = FLUSH;
          exception_taken = 1'b1;
        end else if (!req_sel) begin
          next_state = IDLE;
        end else if (count == SETTLE_LAST) begin
          if (DRAIN_MASK[sel]) next_state = DRAIN;
          else begin
            next_state = FLUSH;
            grant      = sel_onehot;
          end
        end
      end
      DRAIN: begin
        if (preempt) begin
          next_state      = FLUSH;
          exception_taken = 1'b1;
        end else if (drained) begin
          next_state = FLUSH;
          grant      = sel_onehot;
        end
      end
      FLUSH: next_state = DISCARD;
      DISCARD: begin
        if (discard_done) next_state = tlb_pending ? TLB_CLEAR : IDLE;
      end
      TLB_CLEAR: begin
        if (count == TLB_LAST) next_state = IDLE;
      end
      default: next_state = RST;
    endcase
    if (rst) begin
      grant           = '0;
      exception_taken = 1'b0;
    end
    ctrl_next          = decode_ctrl(next_state);
    ctrl_next.sq_flush = (state == DISCARD) && discard_done;
  end

  // Sequencer state, dwell counter, latched channel and TLB flag, and the
  // registered pipeline controls (one cycle behind the next-state decision).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RST;
      count       <= '0;
      sel         <= '0;
      tlb_pending <= 1'b0;
      ctrl        <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)  count <= '0;
      else if (count != CNT_MAX) count <= count + CNT_W'(1);
      if (state == IDLE) begin
        sel         <= pick_idx;
        tlb_pending <= pick_any && !preempt && TLB_MASK[pick_idx];
      end else if ((state == SETTLE || state == DRAIN) && preempt) begin
        tlb_pending <= 1'b0;
      end else if (state == DISCARD && discard_done) begin
        tlb_pending <= 1'b0;
      end
      ctrl <= ctrl_next;
    end
  end

  assign fetch_hold        = ctrl.fetch_hold;
  assign issue_hold        = ctrl.issue_hold;
  assign writeback_supress = ctrl.writeback_supress;
  assign retire_hold       = ctrl.retire_hold;
  assign init_clear        = ctrl.init_clear;
  assign tlb_flush         = ctrl.tlb_flush;
  assign sq_flush          = ctrl.sq_flush;
  assign pc_override       = ctrl.pc_override;

endmodule

// File: tb/tb_gc_flush_sequencer.sv
// Directed bench for gc_flush_sequencer. Inputs change just after a rising
// edge, outputs are sampled on the falling edge. Grant / exception pulses are
// predicted into a queue when the stimulus is driven and matched by a monitor.
module tb_gc_flush_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       oldest_exception;
  logic [6:0] post_issue_count;
  logic       sq_empty;
  logic       stores_drained;
  logic [3:0] grant;
  logic       exception_taken;
  logic       fetch_hold, issue_hold, writeback_supress, retire_hold;
  logic       init_clear, tlb_flush, sq_flush, pc_override;
  logic       busy;

  typedef struct packed {
    logic [3:0] grant;
    logic       exc;
  } sb_evt_t;

  sb_evt_t exp_q[$];
  int total = 0;
  int bad   = 0;

  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_INIT  = 8'b1110_1101;
  localparam logic [7:0] C_SETL  = 8'b0100_0000;
  localparam logic [7:0] C_DRAIN = 8'b1100_0000;
  localparam logic [7:0] C_FLUSH = 8'b1101_0001;
  localparam logic [7:0] C_DISC  = 8'b0110_0000;
  localparam logic [7:0] C_TLB   = 8'b0100_0100;
  localparam logic [7:0] C_TLBSQ = 8'b0100_0110;
  localparam logic [7:0] C_SQ    = 8'b0000_0010;

  gc_flush_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .oldest_exception  (oldest_exception),
    .post_issue_count  (post_issue_count),
    .sq_empty          (sq_empty),
    .stores_drained    (stores_drained),
    .grant             (grant),
    .exception_taken   (exception_taken),
    .fetch_hold        (fetch_hold),
    .issue_hold        (issue_hold),
    .writeback_supress (writeback_supress),
    .retire_hold       (retire_hold),
    .init_clear        (init_clear),
    .tlb_flush         (tlb_flush),
    .sq_flush          (sq_flush),
    .pc_override       (pc_override),
    .busy              (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ctrlVec();
    return {fetch_hold, issue_hold, writeback_supress, retire_hold,
            init_clear, tlb_flush, sq_flush, pc_override};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic e, input logic [6:0] cnt);
    req              = r;
    oldest_exception = e;
    post_issue_count = cnt;
  endtask

  // Sample the current cycle on the falling edge, then move just past the next rising edge.
  task automatic checkCycle(input string tag, input logic exp_busy, input logic [7:0] exp_ctrl,
                            input logic [3:0] exp_grant = 4'b0, input logic exp_exc = 1'b0);
    @(negedge clk);
    checkOutput(tag, 32'({busy, exception_taken, grant, ctrlVec()}),
                     32'({exp_busy, exp_exc, exp_grant, exp_ctrl}));
    @(posedge clk);
    #1;
  endtask

  task automatic countUntilIdle(input string tag, input int exp_busy_n, input int exp_init_n,
                                input int exp_tlb_n, input int exp_sq_n);
    int         busy_n    = 0;
    int         init_n    = 0;
    int         tlb_n     = 0;
    int         sq_n      = 0;
    bit         idle_seen = 0;
    logic [7:0] idle_ctrl = '1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle_seen = 1;
        idle_ctrl = ctrlVec();
        break;
      end
      busy_n++;
      if (init_clear) init_n++;
      if (tlb_flush)  tlb_n++;
      if (sq_flush)   sq_n++;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_reached_idle"}, 32'(idle_seen), 32'd1);
    checkOutput({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy_n));
    checkOutput({tag, "_init_cycles"}, 32'(init_n), 32'(exp_init_n));
    checkOutput({tag, "_tlb_cycles"},  32'(tlb_n),  32'(exp_tlb_n));
    checkOutput({tag, "_sq_pulses"},   32'(sq_n),   32'(exp_sq_n));
    checkOutput({tag, "_idle_ctrl"},   32'(idle_ctrl), 32'(C_NONE));
    if (idle_seen) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every grant or exception pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (grant !== 4'b0 || exception_taken !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected", 32'({exception_taken, grant}), 32'd0);
      end else begin
        sb_evt_t e;
        e = exp_q.pop_front();
        checkOutput("sb_event", 32'({exception_taken, grant}), 32'({e.exc, e.grant}));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst            = 1'b1;
    sq_empty       = 1'b1;
    stores_drained = 1'b1;
    applyStimulus(4'b0000, 1'b0, 7'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset, release, power-on clear
    checkCycle("reset_hold", 1'b1, C_NONE);
    rst = 1'b0;
    checkCycle("rst_state", 1'b1, C_NONE);
    checkCycle("init_first", 1'b1, C_INIT);
    countUntilIdle("init", 63, 63, 63, 0);

    // Interrupt-type channel: settle, drain, flush
    $display("[TB] settle path on channel 3");
    applyStimulus(4'b1000, 1'b0, 7'd0);
    exp_q.push_back('{grant: 4'b1000, exc: 1'b0});
    checkCycle("r40_idle",    1'b0, C_NONE);
    checkCycle("r40_settle0", 1'b1, C_SETL);
    checkCycle("r40_settle1", 1'b1, C_SETL);
    checkCycle("r40_drain",   1'b1, C_DRAIN, 4'b1000);
    applyStimulus(4'b0000, 1'b0, 7'd0);
    checkCycle("r40_flush",   1'b1, C_FLUSH);
    checkCycle("r40_discard", 1'b1, C_DISC);
    checkCycle("r40_sqflush", 1'b0, C_SQ);
    checkCycle("r40_quiet",   1'b0, C_NONE);

    // Two requests at once: lowest index wins and brings a TLB clear
    $display("[TB] priority plus TLB clear");
    applyStimulus(4'b1010, 1'b0, 7'd0);
    stores_drained = 1'b0;
    exp_q.push_back('{grant: 4'b0010, exc: 1'b0});
    checkCycle("r41_idle",     1'b0, C_NONE);
    checkCycle("r41_drain",    1'b1, C_DRAIN, 4'b0010);
    applyStimulus(4'b0000, 1'b0, 7'd0);
    checkCycle("r41_flush",    1'b1, C_FLUSH);
    checkCycle("r41_discard0", 1'b1, C_DISC);
    checkCycle("r41_discard1", 1'b1, C_DISC);
    stores_drained = 1'b1;
    checkCycle("r41_discard2", 1'b1, C_DISC);
    countUntilIdle("r41_tlb", 64, 0, 64, 1);

    // Drain waits for the in-flight count to reach zero
    $display("[TB] drain on post-issue count");
    applyStimulus(4'b0001, 1'b0, 7'd5);
    exp_q.push_back('{grant: 4'b0001, exc: 1'b0});
    checkCycle("r42_idle", 1'b0, C_NONE);
    for (int k = 1; k <= 5; k++) begin
      checkCycle($sformatf("r42_drain%0d", k), 1'b1, C_DRAIN);
      post_issue_count = 7'(5 - k);
    end
    checkCycle("r42_drain_last", 1'b1, C_DRAIN, 4'b0001);
    applyStimulus(4'b0000, 1'b0, 7'd0);
    checkCycle("r42_flush",   1'b1, C_FLUSH);
    checkCycle("r42_discard", 1'b1, C_DISC);
    checkCycle("r42_sqflush", 1'b0, C_SQ);
    checkCycle("r42_quiet",   1'b0, C_NONE);

    // Exception preempts a TLB-channel drain: no grant, no TLB clear
    $display("[TB] exception during drain");
    applyStimulus(4'b0010, 1'b0, 7'd3);
    checkCycle("r43_idle",   1'b0, C_NONE);
    checkCycle("r43_drain1", 1'b1, C_DRAIN);
    checkCycle("r43_drain2", 1'b1, C_DRAIN);
    oldest_exception = 1'b1;
    exp_q.push_back('{grant: 4'b0000, exc: 1'b1});
    checkCycle("r43_drain3", 1'b1, C_DRAIN, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b0, 7'd0);
    checkCycle("r43_flush",   1'b1, C_FLUSH);
    checkCycle("r43_discard", 1'b1, C_DISC);
    checkCycle("r43_sqflush", 1'b0, C_SQ);
    checkCycle("r43_quiet",   1'b0, C_NONE);

    // Exception in IDLE wins over a simultaneous request
    $display("[TB] exception beats request in idle");
    applyStimulus(4'b0100, 1'b1, 7'd0);
    exp_q.push_back('{grant: 4'b0000, exc: 1'b1});
    checkCycle("r20_idle", 1'b0, C_NONE, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b0, 7'd0);
    checkCycle("r20_flush",   1'b1, C_FLUSH);
    checkCycle("r20_discard", 1'b1, C_DISC);
    checkCycle("r20_sqflush", 1'b0, C_SQ);

    // Request withdrawn during settle: back to IDLE, no grant
    $display("[TB] withdrawn request");
    applyStimulus(4'b1000, 1'b0, 7'd0);
    checkCycle("r44_idle",    1'b0, C_NONE);
    checkCycle("r44_settle0", 1'b1, C_SETL);
    req = 4'b0000;
    checkCycle("r44_settle1", 1'b1, C_SETL);
    checkCycle("r44_back",    1'b0, C_NONE);

    // Late request ignored, then reset aborts a TLB clear
    $display("[TB] reset during TLB clear");
    applyStimulus(4'b0010, 1'b0, 7'd0);
    exp_q.push_back('{grant: 4'b0010, exc: 1'b0});
    checkCycle("p2_idle",  1'b0, C_NONE);
    checkCycle("p2_drain", 1'b1, C_DRAIN, 4'b0010);
    req = 4'b0000;
    checkCycle("p2_flush",   1'b1, C_FLUSH);
    checkCycle("p2_discard", 1'b1, C_DISC);
    checkCycle("p2_tlb0",    1'b1, C_TLBSQ);
    req = 4'b1000;
    checkCycle("p2_tlb1",    1'b1, C_TLB);
    checkCycle("p2_tlb2",    1'b1, C_TLB);
    rst              = 1'b1;
    oldest_exception = 1'b1;
    checkCycle("p2_rst_edge",    1'b1, C_TLB);
    checkCycle("p2_rst",         1'b1, C_NONE);
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b0, 7'd0);
    checkCycle("p2_rst_release", 1'b1, C_NONE);
    checkCycle("p2_init_first",  1'b1, C_INIT);
    countUntilIdle("p2_init", 63, 63, 63, 0);

    checkOutput("sb_all_seen", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
